// File: rtl/event_encoder_8to3_pkg.sv
// Shared sizing and helpers for the 8:3 event encoder.
// The encoder collects event strobes and emits one binary index per handshake.
package event_enc_pkg;
  localparam int EVT_N = 8;
  localparam int EVT_W = 3;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [5:0] onehot_lsb(input logic [63:0] v);
    onehot_lsb = '0;
    for (int i = 63; i >= 0; i--)
      if (v[i]) onehot_lsb = 6'(i);
  endfunction
endpackage

// File: rtl/event_encoder_8to3_rr_pick.sv
// Combinational rotating-priority picker: first set bit of cand at or after
// ptr+1 (modulo N) when rr_en, otherwise the lowest set bit.
module rr_pick
  import event_enc_pkg::*;
#(
  parameter int N = EVT_N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  input  logic         rr_en,
  output logic [W-1:0] sel,
  output logic         any
);
  logic [W-1:0] start;
  logic [N-1:0] rot;

  // Rotate so the search origin lands on bit 0, pick lowest, rotate back.
  always_comb begin
    start = rr_en ? W'(ptr + 1'b1) : '0;
    rot   = N'({cand, cand} >> start);
    sel   = W'(onehot_lsb(64'(rot))) + start;
    any   = |cand;
  end
endmodule

// File: rtl/event_encoder_8to3.sv
// Sequential 8:3 encoder: captures event strobes into a pending set and
// emits one encoded index per valid/ready handshake.
module event_encoder_8to3
  import event_enc_pkg::*;
#(
  parameter int N  = EVT_N,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);
  logic [N-1:0] cand;
  logic [N-1:0] sel_mask;
  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic         any;
  logic         slot_free;
  logic         rr_en;

  assign rr_en = (RR != 0);

  always_comb begin
    cand      = pending | (enable ? in : '0);
    slot_free = !out_valid || out_ready;
    sel_mask  = {{(N-1){1'b0}}, 1'b1} << sel;
  end

  rr_pick #(.N(N), .W(W)) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .rr_en (rr_en),
    .sel   (sel),
    .any   (any)
  );

  // ptr resets to N-1 so the first round-robin search begins at line 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= '1;
    end else begin
      // A strobe on a line that is already pending merges away: report it.
      overflow <= enable && |(in & pending);
      if (slot_free) begin
        if (any) begin
          out       <= sel;
          out_valid <= 1'b1;
          ptr       <= sel;
          pending   <= cand & ~sel_mask;
        end else begin
          out_valid <= 1'b0;
          pending   <= cand;
        end
      end else begin
        pending <= cand;
      end
    end
  end
endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench: fixed-priority and round-robin encoders share stimulus;
// expected indices are queued by the stimulus and checked by a monitor.
module tb_event_encoder_8to3;
  typedef struct {
    logic [2:0] i0;
    logic [7:0] p0;
    logic [2:0] i1;
    logic [7:0] p1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, enable, out_ready;
  logic [7:0] in;
  logic [2:0] out0, out1;
  logic       v0, v1, ovf0, ovf1;
  logic [7:0] pend0, pend1;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  event_encoder_8to3 #(.N(8), .W(3), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in), .out(out0),
    .out_valid(v0), .out_ready(out_ready), .pending(pend0), .overflow(ovf0)
  );

  event_encoder_8to3 #(.N(8), .W(3), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in), .out(out1),
    .out_valid(v1), .out_ready(out_ready), .pending(pend1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] i0, input logic [7:0] p0,
                      input logic [2:0] i1, input logic [7:0] p1);
    exp_t e;
    e.i0 = i0; e.p0 = p0; e.i1 = i1; e.p1 = p1;
    q.push_back(e);
  endtask

  task automatic do_reset();
    chk("queue_drained", 64'(q.size()), 0);
    q.delete();
    rst_n = 1'b0; enable = 1'b0; in = '0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: pops on every accept, checks stability while held.
  always @(negedge clk) begin
    if (rst_n && v0) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got out=%0d with no expected entry at %0t", out0, $time);
      end else if (out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("fp_out",   64'(out0),  64'(e.i0));
        chk("fp_pend",  64'(pend0), 64'(e.p0));
        chk("rr_valid", 64'(v1),    1);
        chk("rr_out",   64'(out1),  64'(e.i1));
        chk("rr_pend",  64'(pend1), 64'(e.p1));
      end else begin
        chk("fp_hold", 64'(out0), 64'(q[0].i0));
        chk("rr_hold", 64'(out1), 64'(q[0].i1));
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; in = '0; out_ready = 1'b1;
    tick();
    do_reset();
    chk("rst_valid",  64'(v0),    0);
    chk("rst_out",    64'(out0),  0);
    chk("rst_pend",   64'(pend0), 0);
    chk("rst_ovf",    64'(ovf0),  0);
    chk("rst_valid_rr", 64'(v1),  0);

    // single event
    enable = 1'b1; in = 8'h04;
    push(2, 8'h00, 2, 8'h00);
    tick(); in = '0;
    chk("t1_pend", 64'(pend0), 0);
    tick();
    chk("t1_idle", 64'(v0), 0);

    // multi-hot ordering
    do_reset();
    enable = 1'b1; in = 8'hA2;
    push(1, 8'hA0, 1, 8'hA0);
    push(5, 8'h80, 5, 8'h80);
    push(7, 8'h00, 7, 8'h00);
    tick(); in = '0;
    tick(); tick(); tick();
    chk("t2_idle", 64'(v0), 0);

    // backpressure
    do_reset();
    enable = 1'b1; out_ready = 1'b0; in = 8'h80;
    push(7, 8'h01, 7, 8'h01);
    push(0, 8'h00, 0, 8'h00);
    tick(); in = 8'h01;
    tick(); in = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_held_valid", 64'(v0),   1);
      chk("t3_held_out",   64'(out0), 7);
      chk("t3_held_pend",  64'(pend0), 8'h01);
      tick();
    end
    out_ready = 1'b1;
    tick(); tick();
    chk("t3_idle", 64'(v0), 0);

    // overflow and duplicate-of-slot
    do_reset();
    enable = 1'b1; out_ready = 1'b0; in = 8'h01;
    push(0, 8'h03, 0, 8'h03);
    push(0, 8'h02, 1, 8'h01);
    push(1, 8'h00, 0, 8'h00);
    tick(); in = 8'h02;
    tick();
    chk("t4_ovf_first", 64'(ovf0),  0);
    chk("t4_pend_02",   64'(pend0), 8'h02);
    tick();
    chk("t4_ovf_pulse", 64'(ovf0),  1);
    chk("t4_pend_kept", 64'(pend0), 8'h02);
    in = 8'h01;
    tick(); in = '0;
    chk("t4_ovf_clear", 64'(ovf0),  0);
    chk("t4_pend_03",   64'(pend0), 8'h03);
    chk("t4_ovf_rr",    64'(ovf1),  0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t4_idle", 64'(v0), 0);

    // round-robin versus fixed priority
    do_reset();
    enable = 1'b1; in = 8'h01;
    push(0, 8'h00, 0, 8'h00);
    push(0, 8'h02, 1, 8'h01);
    push(1, 8'h00, 0, 8'h00);
    tick(); in = 8'h03;
    tick(); in = '0;
    tick(); tick();
    chk("t5_idle", 64'(v1), 0);

    // enable gating
    do_reset();
    enable = 1'b0; in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_en_valid", 64'(v0),   0);
      chk("t6_en_pend",  64'(pend0), 0);
    end

    // reset mid-operation
    enable = 1'b1; out_ready = 1'b0; in = 8'h01;
    push(0, 8'h00, 0, 8'h00);
    tick(); in = 8'hF0;
    tick();
    chk("t6_pend_f0", 64'(pend0), 8'hF0);
    chk("t6_slot",    64'(v0),    1);
    in = 8'h10; rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(v0),    0);
    chk("t6_rst_pend",  64'(pend0), 0);
    chk("t6_rst_ovf",   64'(ovf0),  0);
    chk("t6_rst_out",   64'(out0),  0);
    chk("t6_rst_pend_rr", 64'(pend1), 0);
    q.delete();
    rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1; in = 8'h03;
    push(0, 8'h02, 0, 8'h02);
    push(1, 8'h00, 1, 8'h00);
    tick(); in = '0;
    tick(); tick();
    chk("t6_idle", 64'(v0), 0);
    chk("final_queue_drained", 64'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
